// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch requester (I) and the data requester (D).
// One whole transaction is granted at a time; D has priority, and I is guaranteed progress by a starvation counter.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [31:0]         i_data,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_write,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_write,
  output logic [2:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_strobe,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                owner,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // Handshake: a requester raises valid with stable fields and keeps them until its data_ok;
  // the memory port holds mem_valid until the cycle after mem_addr_ok, and the transaction
  // ends in the cycle mem_data_ok is high (addr_ok and data_ok may share a cycle).
  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_write_q, mem_write_d;
  logic [2:0]          mem_size_q, mem_size_d;
  logic [STRB_W-1:0]   mem_strobe_q, mem_strobe_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                grant_d, grant_i;

  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_write_d  = mem_write_q;
    mem_size_d   = mem_size_q;
    mem_strobe_d = mem_strobe_q;
    mem_wdata_d  = mem_wdata_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    grant_d      = 1'b0;
    grant_i      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // I is forced to win once D has taken LIMIT consecutive grants while I waited.
        if (d_valid && !(i_valid && (starve_q == LIMIT))) begin
          grant_d = 1'b1;
        end else if (i_valid) begin
          grant_i = 1'b1;
        end

        if (grant_d) begin
          state_d      = S_BUSY;
          mem_valid_d  = 1'b1;
          mem_addr_d   = d_addr;
          mem_write_d  = d_write;
          mem_size_d   = d_size;
          mem_strobe_d = d_write ? d_strobe : '0;
          mem_wdata_d  = d_wdata;
          owner_d      = 1'b1;
          if (!i_valid) begin
            starve_d = '0;
          end else if (starve_q != LIMIT) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else if (grant_i) begin
          state_d      = S_BUSY;
          mem_valid_d  = 1'b1;
          mem_addr_d   = i_addr;
          mem_write_d  = 1'b0;
          mem_size_d   = 3'd2;
          mem_strobe_d = '0;
          mem_wdata_d  = '0;
          owner_d      = 1'b0;
          starve_d     = '0;
        end
      end
      S_BUSY: begin
        if (mem_addr_ok) begin
          mem_valid_d = 1'b0;
        end
        if (mem_data_ok) begin
          mem_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_size_q   <= 3'd0;
      mem_strobe_q <= '0;
      mem_wdata_q  <= '0;
      owner_q      <= 1'b0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      mem_size_q   <= mem_size_d;
      mem_strobe_q <= mem_strobe_d;
      mem_wdata_q  <= mem_wdata_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
    end
  end

  assign busy       = (state_q == S_BUSY);
  assign owner      = owner_q;
  assign mem_valid  = mem_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_write  = mem_write_q;
  assign mem_size   = mem_size_q;
  assign mem_strobe = mem_strobe_q;
  assign mem_wdata  = mem_wdata_q;

  // Responses reach only the current owner; anything arriving while idle is dropped.
  assign i_addr_ok = busy && !owner_q && mem_addr_ok;
  assign i_data_ok = busy && !owner_q && mem_data_ok;
  assign d_addr_ok = busy &&  owner_q && mem_addr_ok;
  assign d_data_ok = busy &&  owner_q && mem_data_ok;

  // Word select uses the latched address so a misbehaving fetch stage cannot corrupt it.
  assign i_data = mem_addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign d_data = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic, all checked each cycle
// against a transaction-level reference of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid, i_addr_ok, i_data_ok;
  logic [63:0] i_addr;
  logic [31:0] i_data;
  logic        d_valid, d_write, d_addr_ok, d_data_ok;
  logic [63:0] d_addr, d_wdata, d_data;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic        mem_valid, mem_write, mem_addr_ok, mem_data_ok;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_size;
  logic [7:0]  mem_strobe;
  logic        owner, busy;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_data(i_data),
    .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write), .d_size(d_size), .d_strobe(d_strobe),
    .d_wdata(d_wdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_data(d_data),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_write(mem_write), .mem_size(mem_size),
    .mem_strobe(mem_strobe), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference: one transaction in flight at most; what it carries is what the winner asked for.
  bit          m_busy, m_owner, m_mv;
  logic [63:0] m_addr, m_wdata;
  logic        m_write;
  logic [2:0]  m_size;
  logic [7:0]  m_strobe;
  int          m_waits;

  int unsigned i_rate = 0, d_rate = 0, stray_rate = 0;
  int          ta_fix = -1, td_fix = -1;
  bit          rd_fix_en = 0;
  logic [63:0] rd_fix = '0;
  bit          r_open = 0;
  int          r_cnt, r_ta, r_td;
  bit          i_done = 0, d_done = 0, prev_mv = 0;
  int          i_ok_cnt = 0, d_ok_cnt = 0, last_i_cyc = 0, last_d_cyc = 0;
  logic [31:0] last_i_data = '0;
  logic [0:0]  exp_q[$];
  int          grant_cyc_q[$];
  logic [0:0]  exp_bit;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic start_i(input logic [63:0] addr);
    i_valid = 1'b1;
    i_addr  = addr;
  endtask

  task automatic start_d(input logic [63:0] addr, input logic wr, input logic [2:0] sz,
                         input logic [7:0] strb, input logic [63:0] wd);
    d_valid  = 1'b1;
    d_addr   = addr;
    d_write  = wr;
    d_size   = sz;
    d_strobe = strb;
    d_wdata  = wd;
  endtask

  task automatic check_outputs();
    logic e_iaok, e_idok, e_daok, e_ddok;
    e_iaok = m_busy && !m_owner && mem_addr_ok;
    e_idok = m_busy && !m_owner && mem_data_ok;
    e_daok = m_busy && m_owner && mem_addr_ok;
    e_ddok = m_busy && m_owner && mem_data_ok;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("mem_valid", 64'(mem_valid), 64'(m_mv));
    chk("i_addr_ok", 64'(i_addr_ok), 64'(e_iaok));
    chk("i_data_ok", 64'(i_data_ok), 64'(e_idok));
    chk("d_addr_ok", 64'(d_addr_ok), 64'(e_daok));
    chk("d_data_ok", 64'(d_data_ok), 64'(e_ddok));
    if (m_busy) chk("owner", 64'(owner), 64'(m_owner));
    if (m_mv) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_write", 64'(mem_write), 64'(m_write));
      chk("mem_size", 64'(mem_size), 64'(m_size));
      chk("mem_strobe", 64'(mem_strobe), 64'(m_strobe));
      chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_idok) chk("i_data", 64'(i_data), 64'(m_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]));
    if (e_ddok) chk("d_data", d_data, mem_rdata);
  endtask

  task automatic observe();
    if (mem_valid && !prev_mv) begin
      grant_cyc_q.push_back(cyc);
      if (exp_q.size() > 0) begin
        exp_bit = exp_q.pop_front();
        chk("grant_order", 64'(owner), 64'(exp_bit));
      end
    end
    prev_mv = mem_valid;
    if (i_data_ok) begin
      i_done = 1; i_ok_cnt++; last_i_cyc = cyc; last_i_data = i_data;
    end
    if (d_data_ok) begin
      d_done = 1; d_ok_cnt++; last_d_cyc = cyc;
    end
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (d_valid && !(i_valid && m_waits >= LIMIT)) begin
        m_busy = 1; m_mv = 1; m_owner = 1;
        m_addr = d_addr; m_write = d_write; m_size = d_size;
        m_strobe = d_write ? d_strobe : 8'h00; m_wdata = d_wdata;
        m_waits = i_valid ? ((m_waits + 1 > LIMIT) ? LIMIT : m_waits + 1) : 0;
      end else if (i_valid) begin
        m_busy = 1; m_mv = 1; m_owner = 0;
        m_addr = i_addr; m_write = 0; m_size = 3'd2; m_strobe = 8'h00; m_wdata = '0;
        m_waits = 0;
      end
    end else if (mem_data_ok) begin
      m_busy = 0; m_mv = 0;
    end else if (mem_addr_ok) begin
      m_mv = 0;
    end
  endtask

  task automatic drive_inputs();
    if (i_valid && i_done) i_valid = 1'b0;
    i_done = 0;
    if (!i_valid && i_rate > 0 && $urandom_range(99) < i_rate)
      start_i({$urandom(), $urandom()} & ~64'h3);
    if (d_valid && d_done) d_valid = 1'b0;
    d_done = 0;
    if (!d_valid && d_rate > 0 && $urandom_range(99) < d_rate)
      start_d({$urandom(), $urandom()}, 1'($urandom_range(1)), 3'($urandom_range(3)),
              8'($urandom()), {$urandom(), $urandom()});
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    if (!r_open && mem_valid) begin
      r_open = 1; r_cnt = 0;
      r_ta = (ta_fix >= 0) ? ta_fix : int'($urandom_range(2));
      r_td = (td_fix >= 0) ? td_fix : int'($urandom_range(3));
    end
    if (r_open) begin
      if (r_cnt == r_ta) mem_addr_ok = 1'b1;
      if (r_cnt == r_ta + r_td) begin
        mem_data_ok = 1'b1; r_open = 0;
      end
      mem_rdata = rd_fix_en ? rd_fix : {$urandom(), $urandom()};
      r_cnt++;
    end else if (stray_rate > 0 && $urandom_range(99) < stray_rate) begin
      mem_data_ok = 1'b1;
      mem_addr_ok = 1'($urandom_range(1));
      mem_rdata = {$urandom(), $urandom()};
    end
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_outputs();
      observe();
      model_step();
      cyc++;
      @(posedge clk);
      #1;
      drive_inputs();
    end
  endtask

  task automatic clear_inputs();
    i_valid = 0; i_addr = '0; d_valid = 0; d_addr = '0; d_write = 0; d_size = '0;
    d_strobe = '0; d_wdata = '0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    m_busy = 0; m_mv = 0; m_owner = 0; m_waits = 0;
    m_addr = '0; m_wdata = '0; m_write = 0; m_size = '0; m_strobe = '0;
    r_open = 0; prev_mv = 0; i_done = 0; d_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    grant_cyc_q.delete(); exp_q.delete();
    i_ok_cnt = 0; d_ok_cnt = 0;
  endtask

  task automatic drain();
    i_rate = 0; d_rate = 0; stray_rate = 0;
    run_cycles(30);
    ta_fix = -1; td_fix = -1; rd_fix_en = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    clear_inputs();
    #1;
    chk("por_mem_valid", 64'(mem_valid), 64'd0);
    chk("por_busy", 64'(busy), 64'd0);
    chk("por_owner", 64'(owner), 64'd0);
    chk("por_mem_addr", mem_addr, 64'd0);
    chk("por_mem_size", 64'(mem_size), 64'd0);
    do_reset();

    // Reset asserted mid-transaction with a response pending.
    ta_fix = 6; td_fix = 6;
    start_i(64'h100);
    run_cycles(3);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk("pre_rst_i_data_ok", 64'(i_data_ok), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_i_addr_ok", 64'(i_addr_ok), 64'd0);
    chk("rst_i_data_ok", 64'(i_data_ok), 64'd0);
    chk("rst_d_data_ok", 64'(d_data_ok), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_strobe", 64'(mem_strobe), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    do_reset();
    ta_fix = -1; td_fix = -1;

    // Lone fetch from the upper word.
    clear_logs();
    ta_fix = 2; td_fix = 0; rd_fix_en = 1; rd_fix = 64'hAABBCCDD_11223344;
    t0 = cyc;
    start_i(64'h8000_0004);
    run_cycles(8);
    chk("fetch_grants", 64'(grant_cyc_q.size()), 64'd1);
    if (grant_cyc_q.size() > 0) chk("fetch_latency", 64'(grant_cyc_q[0] - t0), 64'd1);
    chk("fetch_i_ok_cycles", 64'(i_ok_cnt), 64'd1);
    chk("fetch_d_ok_cycles", 64'(d_ok_cnt), 64'd0);
    chk("fetch_i_data", 64'(last_i_data), 64'hAABBCCDD);
    drain();

    // Collision: D store wins, I follows two cycles after D completes.
    clear_logs();
    ta_fix = 1; td_fix = 1;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    start_i(64'h2000);
    start_d(64'h3008, 1'b1, 3'd3, 8'h0F, 64'h0123_4567_89AB_CDEF);
    run_cycles(15);
    chk("coll_grants", 64'(grant_cyc_q.size()), 64'd2);
    if (grant_cyc_q.size() >= 2) chk("coll_gap", 64'(grant_cyc_q[1] - last_d_cyc), 64'd2);
    chk("coll_order_consumed", 64'(exp_q.size()), 64'd0);
    drain();

    // Starvation: continuous D traffic with I always waiting.
    clear_logs();
    ta_fix = 0; td_fix = 1; i_rate = 100; d_rate = 100;
    for (int g = 0; g < 2; g++) begin
      repeat (LIMIT) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
    start_i(64'h4000);
    start_d(64'h5000, 1'b0, 3'd3, 8'hFF, 64'd0);
    run_cycles(40);
    chk("starve_order_consumed", 64'(exp_q.size()), 64'd0);
    drain();

    // Split handshake: addr_ok in the first request cycle, data_ok four cycles later.
    clear_logs();
    ta_fix = 0; td_fix = 4;
    start_d(64'h6010, 1'b0, 3'd2, 8'hFF, 64'h55);
    run_cycles(10);
    chk("split_grants", 64'(grant_cyc_q.size()), 64'd1);
    if (grant_cyc_q.size() > 0) chk("split_done_cycle", 64'(last_d_cyc - grant_cyc_q[0]), 64'd4);
    chk("split_d_ok_cycles", 64'(d_ok_cnt), 64'd1);
    drain();

    // Stray response while idle.
    clear_logs();
    mem_data_ok = 1'b1; mem_addr_ok = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_1111;
    run_cycles(3);
    chk("stray_no_ok", 64'(i_ok_cnt + d_ok_cnt), 64'd0);
    chk("stray_no_grant", 64'(grant_cyc_q.size()), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);

    // Randomized mixed traffic with stray responses.
    clear_logs();
    i_rate = 30; d_rate = 30; stray_rate = 10;
    run_cycles(2000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
